// File: rtl/trex_scene_gen.sv
// -----------------------------------------------------------------------------
// trex_scene_gen
//
// Pixel source for the T-rex game display. Sits directly upstream of the VGA
// controller: the controller presents row_addr/col_addr/rdn and latches d_out
// on its next edge, so d_out is purely combinational from the address and the
// active (frame-stable) position registers.
//
// Position updates from game logic land in a shadow set and are copied to the
// active set only on the end-of-frame edge, so a frame never tears. The same
// edge advances the leg-animation frame counter.
//
// Optional feature (compile-time macro TREX_GAMEOVER_BLINK_EN):
//   a 5-bit free-running frame counter blanks the dino for 16 of every 32
//   frames while the active game_over flag is set.
//
// Ports:
//   vga_clk       in   pixel clock (25 MHz)
//   clrn          in   asynchronous active-low reset
//   row_addr[8:0] in   current pixel row, 0..479
//   col_addr[9:0] in   current pixel column, 0..639
//   rdn           in   active-low pixel read strobe from the controller
//   upd           in   one-cycle strobe: capture dino_y_in/obst_x_in/game_over_in
//   dino_y_in     in   dino top row (>=480: not drawn)
//   obst_x_in     in   obstacle left column (>=640: not drawn)
//   game_over_in  in   game-over flag
//   upd_ack       out  one-cycle pulse the cycle after upd is captured
//   frame_tick    out  one-cycle pulse after the last visible pixel of a frame
//   anim_phase    out  current leg phase
//   d_out[11:0]   out  pixel colour, bbbb_gggg_rrrr
// -----------------------------------------------------------------------------
module trex_scene_gen #(
   parameter int          GROUND_ROW  = 400,
   parameter int          DINO_X      = 64,
   parameter int          DINO_W      = 20,
   parameter int          DINO_H      = 22,
   parameter int          OBST_W      = 12,
   parameter int          OBST_H      = 24,
   parameter int          ANIM_FRAMES = 6,
   parameter logic [11:0] COL_BG      = 12'hFFF,
   parameter logic [11:0] COL_FG      = 12'h555,
   parameter logic [11:0] COL_GND     = 12'h777
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   input  logic        rdn,
   input  logic        upd,
   input  logic [8:0]  dino_y_in,
   input  logic [9:0]  obst_x_in,
   input  logic        game_over_in,
   output logic        upd_ack,
   output logic        frame_tick,
   output logic        anim_phase,
   output logic [11:0] d_out
);

   localparam int               CNT_W      = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ANIM_FRAMES - 1);
   localparam logic [8:0]       DINO_Y_RST = 9'(GROUND_ROW - DINO_H);
   localparam logic [9:0]       OBST_X_RST = 10'h3FF;

   // All region bounds in 11 bits so that position + size can never wrap.
   localparam logic [10:0] DX_LO   = 11'(DINO_X);
   localparam logic [10:0] DX_HI   = 11'(DINO_X + DINO_W);
   localparam logic [10:0] DX_MID  = 11'(DINO_X + DINO_W / 2);
   localparam logic [10:0] DH      = 11'(DINO_H);
   localparam logic [10:0] LEG_OFS = 11'(DINO_H - 4);
   localparam logic [10:0] OW      = 11'(OBST_W);
   localparam logic [10:0] OY_LO   = 11'(GROUND_ROW - OBST_H);
   localparam logic [10:0] OY_HI   = 11'(GROUND_ROW);
   localparam logic [10:0] GND_0   = 11'(GROUND_ROW);
   localparam logic [10:0] GND_1   = 11'(GROUND_ROW + 1);

   logic [8:0]       shd_dino_y_q, shd_dino_y_d;
   logic [9:0]       shd_obst_x_q, shd_obst_x_d;
   logic             shd_go_q,     shd_go_d;
   logic             pending_q,    pending_d;
   logic [8:0]       act_dino_y_q, act_dino_y_d;
   logic [9:0]       act_obst_x_q, act_obst_x_d;
   logic             act_go_q,     act_go_d;
   logic [CNT_W-1:0] anim_cnt_q,   anim_cnt_d;
   logic             anim_phase_q, anim_phase_d;
   logic             frame_tick_q, frame_tick_d;
   logic             upd_ack_q,    upd_ack_d;
`ifdef TREX_GAMEOVER_BLINK_EN
   logic [4:0]       blink_cnt_q,  blink_cnt_d;
`endif

   // Last visible pixel read; the edge that samples it is the commit edge.
   logic eof;
   assign eof = !rdn && (row_addr == 9'd479) && (col_addr == 10'd639);

   always_comb begin
      shd_dino_y_d = shd_dino_y_q;
      shd_obst_x_d = shd_obst_x_q;
      shd_go_d     = shd_go_q;
      pending_d    = pending_q;
      act_dino_y_d = act_dino_y_q;
      act_obst_x_d = act_obst_x_q;
      act_go_d     = act_go_q;
      anim_cnt_d   = anim_cnt_q;
      anim_phase_d = anim_phase_q;
      frame_tick_d = eof;
      upd_ack_d    = upd;

      // Commit reads the old shadow even if upd overwrites it on this edge.
      if (eof && pending_q) begin
         act_dino_y_d = shd_dino_y_q;
         act_obst_x_d = shd_obst_x_q;
         act_go_d     = shd_go_q;
      end

      if (upd) begin
         shd_dino_y_d = dino_y_in;
         shd_obst_x_d = obst_x_in;
         shd_go_d     = game_over_in;
         pending_d    = 1'b1;
      end else if (eof) begin
         pending_d    = 1'b0;
      end

      // Freeze decision uses the game_over that was active during this frame.
      if (eof && !act_go_q) begin
         if (anim_cnt_q == CNT_LAST) begin
            anim_cnt_d   = '0;
            anim_phase_d = !anim_phase_q;
         end else begin
            anim_cnt_d   = anim_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef TREX_GAMEOVER_BLINK_EN
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      if (eof) blink_cnt_d = blink_cnt_q + 5'd1;
   end
`endif

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         shd_dino_y_q <= DINO_Y_RST;
         shd_obst_x_q <= OBST_X_RST;
         shd_go_q     <= 1'b0;
         pending_q    <= 1'b0;
         act_dino_y_q <= DINO_Y_RST;
         act_obst_x_q <= OBST_X_RST;
         act_go_q     <= 1'b0;
         anim_cnt_q   <= '0;
         anim_phase_q <= 1'b0;
         frame_tick_q <= 1'b0;
         upd_ack_q    <= 1'b0;
`ifdef TREX_GAMEOVER_BLINK_EN
         blink_cnt_q  <= 5'd0;
`endif
      end else begin
         shd_dino_y_q <= shd_dino_y_d;
         shd_obst_x_q <= shd_obst_x_d;
         shd_go_q     <= shd_go_d;
         pending_q    <= pending_d;
         act_dino_y_q <= act_dino_y_d;
         act_obst_x_q <= act_obst_x_d;
         act_go_q     <= act_go_d;
         anim_cnt_q   <= anim_cnt_d;
         anim_phase_q <= anim_phase_d;
         frame_tick_q <= frame_tick_d;
         upd_ack_q    <= upd_ack_d;
`ifdef TREX_GAMEOVER_BLINK_EN
         blink_cnt_q  <= blink_cnt_d;
`endif
      end
   end

   // ---------------------------------------------------------------- pixels
   logic [10:0] row_w, col_w, dy_w, ox_w;
   logic        dino_on, obst_on, dino_hidden;
   logic        in_dino_box, leg_row, left_half, dino_px, obst_px, gnd_px;

   assign row_w = {2'b00, row_addr};
   assign col_w = {1'b0, col_addr};
   assign dy_w  = {2'b00, act_dino_y_q};
   assign ox_w  = {1'b0, act_obst_x_q};

   assign dino_on = (act_dino_y_q < 9'd480);
   assign obst_on = (act_obst_x_q < 10'd640);

`ifdef TREX_GAMEOVER_BLINK_EN
   assign dino_hidden = act_go_q && blink_cnt_q[4];
`else
   assign dino_hidden = 1'b0;
`endif

   assign in_dino_box = (col_w >= DX_LO) && (col_w < DX_HI)
                     && (row_w >= dy_w) && (row_w < dy_w + DH);
   assign leg_row     = (row_w >= dy_w + LEG_OFS);
   assign left_half   = (col_w < DX_MID);

   // Leg rows draw only one half; phase 0 = left half, phase 1 = right half.
   assign dino_px = dino_on && !dino_hidden && in_dino_box
                 && (!leg_row || (left_half ^ anim_phase_q));

   assign obst_px = obst_on && (col_w >= ox_w) && (col_w < ox_w + OW)
                 && (row_w >= OY_LO) && (row_w < OY_HI);

   assign gnd_px  = (row_w == GND_0) || (row_w == GND_1);

   always_comb begin
      d_out = COL_BG;
      if (rdn)          d_out = 12'h000;
      else if (dino_px) d_out = COL_FG;
      else if (obst_px) d_out = COL_FG;
      else if (gnd_px)  d_out = COL_GND;
   end

   assign upd_ack    = upd_ack_q;
   assign frame_tick = frame_tick_q;
   assign anim_phase = anim_phase_q;

endmodule
